// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package wb_port_arbiter_pkg;
  localparam int NUM_REGS   = 16;
  localparam int REG_ADDR_W = 4;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [31:0]           data;
  } wb_req_t;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_STARVED} starve_st_e;
endpackage

// File: rtl/wb_result_fifo.sv
// Synchronous FIFO of wb_req_t buffering LLU results until a free write slot.
module wb_result_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  localparam int CW        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  wb_req_t       i_din,
  input  logic          i_pop,
  output wb_req_t       o_head,
  output logic [CW-1:0] o_count
);
  localparam int AW = $clog2(FIFO_DEPTH);

  wb_req_t       r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;

  // Depth is a power of two, so the pointers wrap without explicit compare.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wptr] <= i_din;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (i_pop) r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;
endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the regfile write port between WB and the LLU result FIFO; tracks pending LLU writes.
// Optional starvation guard enabled by defining WB_ARB_STARVE_GUARD_EN.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_wb_valid,
  input  logic [REG_ADDR_W-1:0] i_wb_rd,
  input  logic [31:0]           i_wb_data,
  input  logic                  i_llu_valid,
  input  logic [REG_ADDR_W-1:0] i_llu_rd,
  input  logic [31:0]           i_llu_data,
  output logic                  o_llu_ready,
  input  logic                  i_issue_valid,
  input  logic [REG_ADDR_W-1:0] i_issue_rd,
  output logic [NUM_REGS-1:0]   o_pending,
  output logic                  o_rf_we,
  output logic [REG_ADDR_W-1:0] o_rf_rd,
  output logic [31:0]           o_rf_wdata,
  output logic                  o_pipe_stall_req
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  wb_req_t             w_head, w_sel;
  logic [CW-1:0]       w_count;
  logic                w_push, w_pop, w_nonempty;
  logic [NUM_REGS-1:0] w_set, w_clr, r_pending;

  assign w_nonempty  = (w_count != '0);
  assign o_llu_ready = (w_count < CW'(FIFO_DEPTH));
  assign w_push      = i_llu_valid && o_llu_ready;
  assign w_pop       = !i_wb_valid && w_nonempty;

  wb_result_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_din   ({i_llu_rd, i_llu_data}),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count)
  );

  // WB cannot stall, so it always owns the port when it has a write.
  always_comb begin
    w_sel = '0;
    if (i_wb_valid)      w_sel = {i_wb_rd, i_wb_data};
    else if (w_nonempty) w_sel = w_head;
  end

  assign o_rf_we    = (i_wb_valid || w_nonempty) && (w_sel.rd != '0);
  assign o_rf_rd    = w_sel.rd;
  assign o_rf_wdata = w_sel.data;

  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (i_issue_valid) w_set[i_issue_rd] = 1'b1;
    if (w_pop)         w_clr[w_head.rd]  = 1'b1;
  end

  // Set applied after clear so a same-cycle reissue keeps the bit; x0 never pends.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_pending <= '0;
    else          r_pending <= ((r_pending & ~w_clr) | w_set) & ~NUM_REGS'(1);
  end
  assign o_pending = r_pending;

`ifdef WB_ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  starve_st_e    r_state, w_state_nxt;
  logic [SW-1:0] r_cnt, w_cnt_nxt;
  logic [CW-1:0] w_count_nxt;
  logic          r_stall;

  assign w_count_nxt = w_count + CW'(w_push) - CW'(w_pop);

  always_comb begin
    w_cnt_nxt   = r_cnt;
    w_state_nxt = r_state;
    if (!w_nonempty || w_pop)         w_cnt_nxt = '0;
    else if (r_cnt < SW'(STARVE_LIMIT)) w_cnt_nxt = r_cnt + SW'(1);
    if (w_cnt_nxt == SW'(STARVE_LIMIT)) w_state_nxt = ST_STARVED;
    else if (w_count_nxt == '0)         w_state_nxt = ST_IDLE;
    else                                w_state_nxt = ST_WAIT;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_stall <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_stall <= (w_state_nxt == ST_STARVED);
    end
  end

  assign o_pipe_stall_req = r_stall;
`else
  assign o_pipe_stall_req = 1'b0;
`endif
endmodule
